// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use stall.
// The register drives the execute-stage ALU operands directly.

module id_ex_fwd #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic [REG_ADDR-1:0]   ex_rs_i,
  input  logic [DATA_WIDTH-1:0] ex_data_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR-1:0]   mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_alu_result_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR-1:0]   wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] fwd_o
);
  // The younger producer (EX/MEM) has priority. x0 is never forwarded.
  always_comb begin
    fwd_o = ex_data_i;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i))
      fwd_o = mem_alu_result_i;
    else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i))
      fwd_o = wb_data_i;
  end
endmodule

module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int REG_ADDR      = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR-1:0]      id_rs1,
  input  logic [REG_ADDR-1:0]      id_rs2,
  input  logic [REG_ADDR-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic                     id_alu_src,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_branch,
  input  logic                     flush,
  input  logic                     mem_reg_write,
  input  logic [REG_ADDR-1:0]      mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_alu_result,
  input  logic                     wb_reg_write,
  input  logic [REG_ADDR-1:0]      wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [REG_ADDR-1:0]      ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic [31:0]              stall_count
);
  localparam int NUM_SRC = 2;

  logic                     ex_valid_q, ex_alu_src_q;
  logic                     ex_reg_write_q, ex_mem_read_q, ex_mem_write_q, ex_branch_q;
  logic [REG_ADDR-1:0]      ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [DATA_WIDTH-1:0]    ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [OPCODE_LENGTH-1:0] ex_op_q;
  logic [31:0]              stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0][REG_ADDR-1:0]   ex_rs;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] ex_data, fwd;

  // Load in EX whose destination feeds the instruction in ID; a taken branch overrides it.
  assign stall = !flush && id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                 ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_branch_q    <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_rs1_data_q  <= '0;
      ex_rs2_data_q  <= '0;
      ex_imm_q       <= '0;
      ex_op_q        <= '0;
      stall_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (flush || stall) begin
        ex_valid_q     <= 1'b0;
        ex_alu_src_q   <= 1'b0;
        ex_reg_write_q <= 1'b0;
        ex_mem_read_q  <= 1'b0;
        ex_mem_write_q <= 1'b0;
        ex_branch_q    <= 1'b0;
        ex_rs1_q       <= '0;
        ex_rs2_q       <= '0;
        ex_rd_q        <= '0;
        ex_rs1_data_q  <= '0;
        ex_rs2_data_q  <= '0;
        ex_imm_q       <= '0;
        ex_op_q        <= '0;
      end else begin
        ex_valid_q     <= id_valid;
        ex_alu_src_q   <= id_alu_src;
        ex_reg_write_q <= id_valid & id_reg_write;
        ex_mem_read_q  <= id_valid & id_mem_read;
        ex_mem_write_q <= id_valid & id_mem_write;
        ex_branch_q    <= id_valid & id_branch;
        ex_rs1_q       <= id_rs1;
        ex_rs2_q       <= id_rs2;
        ex_rd_q        <= id_rd;
        ex_rs1_data_q  <= id_rs1_data;
        ex_rs2_data_q  <= id_rs2_data;
        ex_imm_q       <= id_imm;
        ex_op_q        <= id_operation;
      end
    end
  end

  assign ex_rs[0]   = ex_rs1_q;
  assign ex_rs[1]   = ex_rs2_q;
  assign ex_data[0] = ex_rs1_data_q;
  assign ex_data[1] = ex_rs2_data_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    id_ex_fwd #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR(REG_ADDR)) u_fwd (
      .ex_rs_i         (ex_rs[g]),
      .ex_data_i       (ex_data[g]),
      .mem_reg_write_i (mem_reg_write),
      .mem_rd_i        (mem_rd),
      .mem_alu_result_i(mem_alu_result),
      .wb_reg_write_i  (wb_reg_write),
      .wb_rd_i         (wb_rd),
      .wb_data_i       (wb_data),
      .fwd_o           (fwd[g])
    );
  end

  assign SrcA          = fwd[0];
  assign SrcB          = ex_alu_src_q ? ex_imm_q : fwd[1];
  assign ex_store_data = fwd[1];
  assign Operation     = ex_op_q;
  assign ex_valid      = ex_valid_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_branch     = ex_branch_q;
  assign stall_count   = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, load-use stall, flush, reset, counter saturation.

module tb_id_ex_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, mem_alu_result, wb_data;
  logic [3:0]  id_operation, Operation;
  logic        mem_reg_write, wb_reg_write, stall;
  logic [31:0] SrcA, SrcB, ex_store_data, stall_count;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int n_vec = 0, n_err = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_operation(id_operation), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one instruction in ID.
  task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [3:0] op, input logic asrc, input logic rw, input logic mr,
                        input logic mw, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_operation = op; id_alu_src = asrc; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_branch = br;
    #1;
  endtask

  task automatic bypass(input logic mw_en, input logic [4:0] mrd, input logic [31:0] mres,
                        input logic ww_en, input logic [4:0] wrd, input logic [31:0] wdat);
    mem_reg_write = mw_en; mem_rd = mrd; mem_alu_result = mres;
    wb_reg_write = ww_en; wb_rd = wrd; wb_data = wdat;
    #1;
  endtask

  initial begin
    flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bypass(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, Operation}, 32'd0);
    chk("rst_cnt", stall_count, 32'd0);
    chk("rst_srca", SrcA, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Back-to-back ALU RAW through EX/MEM
    id_set(1, 1, 2, 5, 32'h8, 32'h8, 0, 4'h2, 0, 1, 0, 0, 0);
    tick();
    id_set(1, 5, 5, 6, 32'h111, 32'h222, 0, 4'h2, 0, 1, 0, 0, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bypass(1, 5, 32'h10, 0, 0, 0);
    chk("raw_srca", SrcA, 32'h10);
    chk("raw_srcb", SrcB, 32'h10);
    chk("raw_stall", {31'd0, stall}, 32'd0);
    chk("raw_rd", {27'd0, ex_rd}, 32'd6);

    // EX/MEM beats MEM/WB; immediate selects SrcB, store data stays on rs2
    id_set(1, 7, 8, 9, 32'h1, 32'h2, 32'h44, 4'h3, 1, 1, 0, 0, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bypass(1, 7, 32'hAA, 1, 7, 32'hBB);
    chk("dbl_srca", SrcA, 32'hAA);
    chk("dbl_srcb_imm", SrcB, 32'h44);
    chk("dbl_store", ex_store_data, 32'h2);
    chk("dbl_op", {28'd0, Operation}, 32'h3);
    bypass(0, 7, 32'hAA, 1, 7, 32'hBB);
    chk("wb_srca", SrcA, 32'hBB);
    bypass(0, 7, 32'hAA, 0, 7, 32'hBB);
    chk("rf_srca", SrcA, 32'h1);
    bypass(1, 8, 32'hCC, 0, 0, 0);
    chk("store_fwd", ex_store_data, 32'hCC);
    bypass(0, 0, 0, 0, 0, 0);

    // Load-use: lw x3, then add x9,x1,x3
    id_set(1, 2, 0, 3, 32'h1000, 0, 0, 4'h2, 1, 1, 1, 0, 0);
    tick();
    id_set(1, 1, 3, 9, 32'h5, 32'hDEAD, 0, 4'h2, 0, 1, 0, 0, 0);
    chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    bypass(1, 3, 32'h1000, 0, 0, 0);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_cnt", stall_count, 32'd1);
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    tick();
    bypass(0, 0, 0, 1, 3, 32'h55);
    chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cap_rd", {27'd0, ex_rd}, 32'd9);
    chk("lu_srcb", SrcB, 32'h55);
    chk("lu_srca", SrcA, 32'h5);
    chk("lu_cnt_hold", stall_count, 32'd1);
    bypass(0, 0, 0, 0, 0, 0);

    // x0 guard: load to x0 never stalls, x0 is never forwarded
    id_set(1, 0, 0, 0, 0, 0, 0, 4'h2, 1, 1, 1, 0, 0);
    tick();
    id_set(1, 0, 0, 4, 0, 0, 0, 4'h2, 0, 1, 0, 0, 0);
    bypass(1, 0, 32'h77, 1, 0, 32'h88);
    chk("x0_stall", {31'd0, stall}, 32'd0);
    chk("x0_srca", SrcA, 32'd0);
    chk("x0_memrd", {31'd0, ex_mem_read}, 32'd1);
    bypass(0, 0, 0, 0, 0, 0);

    // Flush coinciding with a load-use condition
    id_set(1, 1, 0, 4, 0, 0, 0, 4'h2, 1, 1, 1, 0, 0);
    tick();
    id_set(1, 4, 0, 5, 0, 0, 0, 4'h2, 0, 1, 0, 0, 1);
    chk("fl_pre_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1; #1;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0; #1;
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_branch", {31'd0, ex_branch}, 32'd0);
    chk("fl_cnt", stall_count, 32'd1);

    // Async reset while a load-use stall is pending
    id_set(1, 1, 0, 4, 0, 0, 0, 4'h6, 1, 1, 1, 0, 0);
    tick();
    id_set(1, 0, 4, 5, 0, 0, 0, 4'h2, 0, 1, 0, 0, 0);
    chk("ar_pre_stall", {31'd0, stall}, 32'd1);
    chk("ar_pre_op", {28'd0, Operation}, 32'h6);
    #1 reset = 1'b1; #1;
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_valid", {31'd0, ex_valid}, 32'd0);
    chk("ar_op", {28'd0, Operation}, 32'd0);
    chk("ar_cnt", stall_count, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Saturation: preset near the top, then two stalls
    id_set(1, 1, 0, 4, 0, 0, 0, 4'h2, 1, 1, 1, 0, 0);
    tick();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    id_set(1, 4, 0, 5, 0, 0, 0, 4'h2, 0, 1, 0, 0, 0);
    tick();
    chk("sat_1", stall_count, 32'hFFFF_FFFF);
    id_set(1, 1, 0, 4, 0, 0, 0, 4'h2, 1, 1, 1, 0, 0);
    tick();
    id_set(1, 4, 0, 5, 0, 0, 0, 4'h2, 0, 1, 0, 0, 0);
    chk("sat_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("sat_hold", stall_count, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
